// File: rtl/return_stack.sv
// Return-address stack: holds return PCs pushed by stack_control and exposes the
// architectural stack pointer, the current top entry, a registered pop result and sticky error flags.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int SP_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [SP_W-1:0]  sp,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             empty,
    output logic             full,
    output logic             overflow_err,
    output logic             underflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             do_write;
    logic             do_pop;
    logic             set_ovf;
    logic             set_unf;

    assign top_idx  = AW'(cnt - CW'(1));
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign sp       = SP_W'(cnt);
    assign top_data = empty ? '0 : mem[top_idx];

    // push and pop are level requests with no back-pressure: whatever is asserted at a
    // rising edge is acted on at that edge; refused requests only raise the sticky flags.
    always_comb begin
        do_write = 1'b0;
        do_pop   = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        cnt_next = cnt;
        wr_idx   = cnt[AW-1:0];
        case ({push, pop})
            2'b10: begin
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    do_write = 1'b1;
                    cnt_next = cnt + CW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    set_unf = 1'b1;
                end else begin
                    do_pop   = 1'b1;
                    cnt_next = cnt - CW'(1);
                end
            end
            2'b11: begin
                do_write = 1'b1;
                if (empty) begin
                    set_unf  = 1'b1;
                    cnt_next = cnt + CW'(1);
                end else begin
                    // Replace-top: old top leaves through pop_data, new value takes its slot.
                    wr_idx = top_idx;
                    do_pop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            pop_data      <= '0;
            pop_valid     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            pop_valid <= do_pop;
            if (do_pop) pop_data <= mem[top_idx];
            if (set_ovf) overflow_err <= 1'b1;
            if (set_unf) underflow_err <= 1'b1;
        end
    end

    // Storage is never cleared; reset only blocks a write requested in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset && do_write) mem[wr_idx] <= push_data;
    end
endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: directed test-plan sequences with literal expectations, then
// randomized push/pop/reset traffic compared every cycle against a queue-based model.
module tb_return_stack;
    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int SP_W  = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] top_data;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             empty;
    logic             full;
    logic             overflow_err;
    logic             underflow_err;

    return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SP_W(SP_W)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
        .sp(sp), .top_data(top_data), .pop_data(pop_data), .pop_valid(pop_valid),
        .empty(empty), .full(full), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: the stack is a queue whose back is the top.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_pop_data;
    logic             m_pop_valid;
    logic             m_ovf;
    logic             m_unf;
    bit               model_ok = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit pu, input bit po, input logic [WIDTH-1:0] d);
        if (r) begin
            exp_q.delete();
            m_pop_data  = '0;
            m_pop_valid = 1'b0;
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            model_ok    = 1'b1;
        end else begin
            m_pop_valid = 1'b0;
            if (pu && po) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back(d);
                    m_unf = 1'b1;
                end else begin
                    m_pop_data = exp_q[exp_q.size()-1];
                    exp_q[exp_q.size()-1] = d;
                    m_pop_valid = 1'b1;
                end
            end else if (pu) begin
                if (exp_q.size() == DEPTH) m_ovf = 1'b1;
                else exp_q.push_back(d);
            end else if (po) begin
                if (exp_q.size() == 0) m_unf = 1'b1;
                else begin
                    m_pop_data  = exp_q.pop_back();
                    m_pop_valid = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle, update the model at the edge, return 1 time unit after it.
    task automatic step(input bit r, input bit pu, input bit po, input logic [WIDTH-1:0] d);
        reset = r; push = pu; pop = po; push_data = d;
        @(posedge clk);
        model_update(r, pu, po, d);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    // Every-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("sp", 64'(sp), 64'(exp_q.size()));
            chk("top_data", 64'(top_data), exp_q.size() == 0 ? 64'd0 : 64'(exp_q[exp_q.size()-1]));
            chk("pop_data", 64'(pop_data), 64'(m_pop_data));
            chk("pop_valid", 64'(pop_valid), 64'(m_pop_valid));
            chk("empty", 64'(empty), 64'(exp_q.size() == 0));
            chk("full", 64'(full), 64'(exp_q.size() == DEPTH));
            chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
            chk("underflow_err", 64'(underflow_err), 64'(m_unf));
        end
    end

    initial begin
        // 1: reset dominates push+pop
        step(1, 1, 1, 32'hdead);
        chk("t1_sp", 64'(sp), 64'd0);
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_pop_valid", 64'(pop_valid), 64'd0);
        chk("t1_errs", 64'({overflow_err, underflow_err}), 64'd0);

        // 2: three pushes then three back-to-back pops
        step(0, 1, 0, 32'h100);
        step(0, 1, 0, 32'h104);
        step(0, 1, 0, 32'h108);
        chk("t2_sp", 64'(sp), 64'd3);
        chk("t2_top", 64'(top_data), 64'h108);
        step(0, 0, 1, 0);
        chk("t2_pop1", 64'({pop_valid, pop_data}), {31'd0, 1'b1, 32'h108});
        step(0, 0, 1, 0);
        chk("t2_pop2", 64'({pop_valid, pop_data}), {31'd0, 1'b1, 32'h104});
        step(0, 0, 1, 0);
        chk("t2_pop3", 64'({pop_valid, pop_data}), {31'd0, 1'b1, 32'h100});
        chk("t2_sp_end", 64'(sp), 64'd0);
        chk("t2_empty", 64'(empty), 64'd1);
        step(0, 0, 0, 0);
        chk("t2_valid_drop", 64'({pop_valid, pop_data}), {31'd0, 1'b0, 32'h100});

        // 3: fill, overflow, sticky flag survives a pop
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 32'h10 + 32'(i));
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_sp", 64'(sp), 64'd8);
        step(0, 1, 0, 32'hff);
        chk("t3_sp_ovf", 64'(sp), 64'd8);
        chk("t3_top", 64'(top_data), 64'h17);
        chk("t3_ovf", 64'(overflow_err), 64'd1);
        step(0, 0, 1, 0);
        chk("t3_ovf_sticky", 64'(overflow_err), 64'd1);
        chk("t3_pop", 64'(pop_data), 64'h17);

        // 4: underflow from empty, then push
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("t4_unf", 64'(underflow_err), 64'd1);
        chk("t4_pop_valid", 64'(pop_valid), 64'd0);
        chk("t4_sp", 64'(sp), 64'd0);
        step(0, 1, 0, 32'h20);
        chk("t4_sp_push", 64'(sp), 64'd1);
        chk("t4_top", 64'(top_data), 64'h20);

        // 5: replace-top at sp=2
        step(0, 1, 0, 32'h44);
        step(0, 1, 1, 32'h55);
        chk("t5_pop", 64'({pop_valid, pop_data}), {31'd0, 1'b1, 32'h44});
        chk("t5_sp", 64'(sp), 64'd2);
        chk("t5_top", 64'(top_data), 64'h55);

        // 6: reset mid-pop with sp=3 and both flags set
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 32'h30 + 32'(i));
        step(0, 1, 0, 32'h3f);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        chk("t6_pre", 64'({overflow_err, underflow_err, sp[3:0]}), 64'h33);
        step(1, 0, 1, 0);
        chk("t6_sp", 64'(sp), 64'd0);
        chk("t6_errs", 64'({overflow_err, underflow_err}), 64'd0);
        chk("t6_pop_valid", 64'(pop_valid), 64'd0);

        // Randomized traffic, biased to reach both full and empty.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0) step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
            else if (r < 45) step(0, 1, 0, $urandom);
            else if (r < 80) step(0, 0, 1, 0);
            else if (r < 92) step(0, 1, 1, $urandom);
            else step(0, 0, 0, $urandom);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
